// File: rtl/xor_share_sched.sv
// Round-robin scheduler that time-shares one XOR unit and one AND-mask unit among NREQ requesters.
// Optional accept counter port stat_accepts is enabled by defining XOR_SHARE_SCHED_STATS_EN.
module xor_share_sched #(
    parameter int unsigned       NREQ  = 4,
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  MASK  = {WIDTH{1'b1}},
    localparam int unsigned      IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_in1,
    input  logic [NREQ*WIDTH-1:0]   req_in2,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
`ifdef XOR_SHARE_SCHED_STATS_EN
    ,
    output logic [15:0]             stat_accepts
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic [WIDTH-1:0]   op2_q, op2_d;
    logic [WIDTH-1:0]   w_q, w_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     scan_idx;
    logic               accept;
    logic [WIDTH-1:0]   xor_a, xor_b, xor_y;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            scan_idx = IDW'((32'(ptr_q) + i) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign accept = (state_q == IDLE) && rst_n && grant_found;

    // The single shared XOR unit; operands steered by pass.
    always_comb begin
        xor_a = '0;
        xor_b = '0;
        case (state_q)
            PASS1: begin
                xor_a = op1_q;
                xor_b = op2_q;
            end
            PASS2: begin
                xor_a = w_q;
                xor_b = op2_q & MASK;
            end
            default: ;
        endcase
    end

    assign xor_y = xor_a ^ xor_b;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        w_d         = w_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready[grant_idx] = 1'b1;
                    op1_d   = req_in1[32'(grant_idx) * WIDTH +: WIDTH];
                    op2_d   = req_in2[32'(grant_idx) * WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    ptr_d   = grant_idx;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                w_d     = xor_y & MASK;
                state_d = PASS2;
            end
            PASS2: begin
                rsp_data_d  = xor_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            w_q         <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            w_q         <= w_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

`ifdef XOR_SHARE_SCHED_STATS_EN
    logic [15:0] stat_q, stat_d;

    // Saturating count of accepted requests.
    always_comb begin
        stat_d = stat_q;
        if (accept && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_accepts = stat_q;
`endif

endmodule

// File: tb/tb_xor_share_sched.sv
// Scoreboard bench for xor_share_sched: default-mask instance plus a MASK=8'h0F instance.
module tb_xor_share_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid, req_ready;
    logic [NREQ*WIDTH-1:0] req_in1, req_in2;
    logic                  rsp_valid, rsp_ready, busy;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;

    logic [NREQ-1:0]       m_req_valid, m_req_ready;
    logic [NREQ*WIDTH-1:0] m_req_in1, m_req_in2;
    logic                  m_rsp_valid, m_rsp_ready, m_busy;
    logic [WIDTH-1:0]      m_rsp_data;
    logic [IDW-1:0]        m_rsp_id;

`ifdef XOR_SHARE_SCHED_STATS_EN
    logic [15:0] stat_accepts, m_stat_accepts;
`endif

    xor_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
`ifdef XOR_SHARE_SCHED_STATS_EN
        , .stat_accepts(stat_accepts)
`endif
    );

    xor_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MASK(8'h0F)) dut_m (
        .clk(clk), .rst_n(rst_n),
        .req_valid(m_req_valid), .req_ready(m_req_ready),
        .req_in1(m_req_in1), .req_in2(m_req_in2),
        .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready),
        .rsp_data(m_rsp_data), .rsp_id(m_rsp_id), .busy(m_busy)
`ifdef XOR_SHARE_SCHED_STATS_EN
        , .stat_accepts(m_stat_accepts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t        sb[$];
    int unsigned grant_log[$];
    int unsigned acc_cyc_log[$];
    int unsigned lat_q[$];
    int unsigned cyc = 0;
    int unsigned stat_exp = 0;
    logic        prev_valid = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] mask);
        return ((a ^ b) & mask) ^ (b & mask);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push expectations at accept, pop and compare at response handshake.
    always @(negedge clk) begin
        exp_t        e;
        int          g;
        int unsigned a;
        if (rst_n) begin
            if (rsp_valid && !prev_valid) begin
                if (lat_q.size() == 0) check("unexpected_rsp", 1, 0);
                else begin
                    a = lat_q.pop_front();
                    check("latency", cyc - (a + 1), 2);
                end
            end
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) check("sb_empty", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_id", rsp_id, e.id);
                end
            end
            if (|(req_valid & req_ready)) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                e.id   = IDW'(g);
                e.data = model(req_in1[g*WIDTH +: WIDTH], req_in2[g*WIDTH +: WIDTH], 8'hFF);
                sb.push_back(e);
                grant_log.push_back(g);
                acc_cyc_log.push_back(cyc);
                lat_q.push_back(cyc);
                stat_exp++;
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        sb.delete();
        lat_q.delete();
        stat_exp = 0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        flush_model();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_in1[i*WIDTH +: WIDTH] = a;
        req_in2[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_grants(input int n, input string tag);
        int k = 0;
        while (grant_log.size() < n && k < 60) begin
            tick();
            k++;
        end
        check({tag, "_grant_timeout"}, k < 60, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((busy || rsp_valid || sb.size() != 0) && k < 60) begin
            tick();
            k++;
        end
        check({tag, "_idle_timeout"}, k < 60, 1);
    endtask

    initial begin
        int          base;
        int          k;
        int unsigned rel_cyc;
        int unsigned exp_order[5];

        rst_n       = 1'b0;
        req_valid   = '0;
        req_in1     = '0;
        req_in2     = '0;
        rsp_ready   = 1'b0;
        m_req_valid = '0;
        m_req_in1   = '0;
        m_req_in2   = '0;
        m_rsp_ready = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_req_ready", req_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single request
        rsp_ready = 1'b1;
        set_op(0, 8'hA5, 8'h3C);
        req_valid = 4'b0001;
        #1;
        check("t1_req_ready", req_ready, 4'b0001);
        wait_grants(1, "t1");
        req_valid = '0;
        wait_idle("t1");

        // Round-robin from fresh reset
        do_reset();
        grant_log.delete();
        acc_cyc_log.delete();
        for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(8'h13 * (i + 1)), WIDTH'(8'h71 + 8'h22 * i));
        req_valid = 4'b1111;
        wait_grants(5, "t2");
        req_valid = '0;
        wait_idle("t2");
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check("t2_order", grant_log[i], exp_order[i]);
        for (int i = 1; i < 5; i++) check("t2_spacing", acc_cyc_log[i] - acc_cyc_log[i-1], 4);

        // Backpressure
        rsp_ready = 1'b0;
        set_op(1, 8'hC3, 8'h96);
        req_valid = 4'b0010;
        base = grant_log.size();
        wait_grants(base + 1, "t3");
        set_op(2, 8'h5E, 8'hE1);
        req_valid = 4'b0100;
        k = 0;
        while (!rsp_valid && k < 10) begin
            tick();
            k++;
        end
        check("t3_rsp_timeout", k < 10, 1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", rsp_valid, 1);
            check("t3_hold_data", rsp_data, model(8'hC3, 8'h96, 8'hFF));
            check("t3_hold_id", rsp_id, 1);
            check("t3_hold_ready", req_ready, 0);
            check("t3_hold_busy", busy, 1);
            tick();
        end
        rel_cyc   = cyc;
        rsp_ready = 1'b1;
        wait_grants(base + 2, "t3b");
        req_valid = '0;
        check("t3_next_id", grant_log[base+1], 2);
        check("t3_next_gap", acc_cyc_log[base+1] - rel_cyc, 1);
        wait_idle("t3");

        // Wrap and skip: last served is 2
        set_op(0, 8'h0F, 8'hF0);
        set_op(1, 8'h81, 8'h18);
        req_valid = 4'b0011;
        base = grant_log.size();
        wait_grants(base + 2, "t4");
        req_valid = '0;
        check("t4_first", grant_log[base], 0);
        check("t4_second", grant_log[base+1], 1);
        wait_idle("t4");

        // Asynchronous reset while in PASS2
        set_op(0, 8'h77, 8'h12);
        req_valid = 4'b0001;
        base = grant_log.size();
        wait_grants(base + 1, "t5");
        req_valid = '0;
        tick();
        check("t5_busy_pass2", busy, 1);
        #2;
        rst_n = 1'b0;
        flush_model();
        #1;
        check("t5_async_busy", busy, 0);
        check("t5_async_valid", rsp_valid, 0);
        check("t5_async_ready", req_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        set_op(3, 8'h3A, 8'hC5);
        req_valid = 4'b1001;
        base = grant_log.size();
        wait_grants(base + 2, "t5b");
        req_valid = '0;
        check("t5_first", grant_log[base], 0);
        check("t5_second", grant_log[base+1], 3);
        wait_idle("t5");

`ifdef XOR_SHARE_SCHED_STATS_EN
        check("stat_accepts", stat_accepts, stat_exp);
`endif

        // Narrow mask instance
        m_rsp_ready           = 1'b1;
        m_req_in1[WIDTH-1:0]  = 8'hFF;
        m_req_in2[WIDTH-1:0]  = 8'h5A;
        m_req_valid           = 4'b0001;
        #1;
        check("m_req_ready", m_req_ready, 4'b0001);
        tick();
        m_req_valid = '0;
        k = 0;
        while (!m_rsp_valid && k < 10) begin
            tick();
            k++;
        end
        check("m_rsp_timeout", k < 10, 1);
        check("m_rsp_data", m_rsp_data, model(8'hFF, 8'h5A, 8'h0F));
        check("m_rsp_id", m_rsp_id, 0);
        tick();
`ifdef XOR_SHARE_SCHED_STATS_EN
        check("m_stat_accepts", m_stat_accepts, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
